// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: one valid/ready command in, one bus
// transfer (with retry/backoff and timeout handling), one held response out.
module wb_cmd_master #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int MAX_RETRY      = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_we,
   input  logic [ADDR_WIDTH-1:0]   cmd_adr,
   input  logic [DATA_WIDTH-1:0]   cmd_dat,
   input  logic [SELECT_WIDTH-1:0] cmd_sel,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_dat,
   output logic [1:0]              rsp_status,
   output logic [ADDR_WIDTH-1:0]   wb_adr_o,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   output logic [SELECT_WIDTH-1:0] wb_sel_o,
   output logic                    wb_we_o,
   output logic                    wb_cyc_o,
   output logic                    wb_stb_o,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   input  logic                    wb_ack_i,
   input  logic                    wb_err_i,
   input  logic                    wb_rty_i
);

   localparam int WAIT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [WAIT_W-1:0]  WAIT_LAST   = WAIT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [WAIT_W-1:0]  WAIT_MAX    = '1;
   localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

   localparam logic [1:0] STATUS_OK         = 2'b00;
   localparam logic [1:0] STATUS_ERR        = 2'b01;
   localparam logic [1:0] STATUS_TIMEOUT    = 2'b10;
   localparam logic [1:0] STATUS_RETRY_FAIL = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUS,
      S_BACKOFF,
      S_RESP
   } state_t;

   state_t                  state_reg, state_next;
   logic [WAIT_W-1:0]       wait_cnt_reg, wait_cnt_next;
   logic [RETRY_W-1:0]      retry_cnt_reg, retry_cnt_next;
   logic                    cyc_reg, cyc_next;
   logic                    we_reg, we_next;
   logic [ADDR_WIDTH-1:0]   adr_reg, adr_next;
   logic [DATA_WIDTH-1:0]   dat_reg, dat_next;
   logic [SELECT_WIDTH-1:0] sel_reg, sel_next;
   logic                    rsp_valid_reg, rsp_valid_next;
   logic [DATA_WIDTH-1:0]   rsp_dat_reg, rsp_dat_next;
   logic [1:0]              rsp_status_reg, rsp_status_next;
   logic                    timeout_hit;

   // A zero timeout parameter removes the timeout path entirely.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt_reg == WAIT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= S_IDLE;
         wait_cnt_reg   <= '0;
         retry_cnt_reg  <= '0;
         cyc_reg        <= 1'b0;
         we_reg         <= 1'b0;
         adr_reg        <= '0;
         dat_reg        <= '0;
         sel_reg        <= '0;
         rsp_valid_reg  <= 1'b0;
         rsp_dat_reg    <= '0;
         rsp_status_reg <= STATUS_OK;
      end else begin
         state_reg      <= state_next;
         wait_cnt_reg   <= wait_cnt_next;
         retry_cnt_reg  <= retry_cnt_next;
         cyc_reg        <= cyc_next;
         we_reg         <= we_next;
         adr_reg        <= adr_next;
         dat_reg        <= dat_next;
         sel_reg        <= sel_next;
         rsp_valid_reg  <= rsp_valid_next;
         rsp_dat_reg    <= rsp_dat_next;
         rsp_status_reg <= rsp_status_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      wait_cnt_next   = wait_cnt_reg;
      retry_cnt_next  = retry_cnt_reg;
      cyc_next        = cyc_reg;
      we_next         = we_reg;
      adr_next        = adr_reg;
      dat_next        = dat_reg;
      sel_next        = sel_reg;
      rsp_valid_next  = rsp_valid_reg;
      rsp_dat_next    = rsp_dat_reg;
      rsp_status_next = rsp_status_reg;

      case (state_reg)
         S_IDLE: begin
            if (cmd_valid) begin
               we_next        = cmd_we;
               adr_next       = cmd_adr;
               dat_next       = cmd_dat;
               sel_next       = cmd_sel;
               cyc_next       = 1'b1;
               wait_cnt_next  = '0;
               retry_cnt_next = '0;
               state_next     = S_BUS;
            end
         end
         S_BUS: begin
            // Termination priority: ERR over ACK over RTY over timeout.
            if (wb_err_i) begin
               cyc_next        = 1'b0;
               rsp_dat_next    = '0;
               rsp_status_next = STATUS_ERR;
               rsp_valid_next  = 1'b1;
               state_next      = S_RESP;
            end else if (wb_ack_i) begin
               cyc_next        = 1'b0;
               rsp_dat_next    = we_reg ? '0 : wb_dat_i;
               rsp_status_next = STATUS_OK;
               rsp_valid_next  = 1'b1;
               state_next      = S_RESP;
            end else if (wb_rty_i) begin
               cyc_next = 1'b0;
               if (retry_cnt_reg < RETRY_LIMIT) begin
                  retry_cnt_next = retry_cnt_reg + RETRY_W'(1);
                  state_next     = S_BACKOFF;
               end else begin
                  rsp_dat_next    = '0;
                  rsp_status_next = STATUS_RETRY_FAIL;
                  rsp_valid_next  = 1'b1;
                  state_next      = S_RESP;
               end
            end else if (timeout_hit) begin
               cyc_next        = 1'b0;
               rsp_dat_next    = '0;
               rsp_status_next = STATUS_TIMEOUT;
               rsp_valid_next  = 1'b1;
               state_next      = S_RESP;
            end else if (wait_cnt_reg != WAIT_MAX) begin
               wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
            end
         end
         S_BACKOFF: begin
            cyc_next      = 1'b1;
            wait_cnt_next = '0;
            state_next    = S_BUS;
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_next = 1'b0;
               retry_cnt_next = '0;
               wait_cnt_next  = '0;
               state_next     = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign cmd_ready  = (state_reg == S_IDLE);
   assign wb_cyc_o   = cyc_reg;
   assign wb_stb_o   = cyc_reg;
   assign wb_we_o    = we_reg;
   assign wb_adr_o   = adr_reg;
   assign wb_dat_o   = dat_reg;
   assign wb_sel_o   = sel_reg;
   assign rsp_valid  = rsp_valid_reg;
   assign rsp_dat    = rsp_dat_reg;
   assign rsp_status = rsp_status_reg;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: scripted Wishbone slave, transaction-level outcome model
// and a per-cycle interface checker.
module tb_wb_cmd_master;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int SW = 4;
   localparam int TO = 8;
   localparam int MR = 3;

   localparam int K_ACK = 0, K_ERR = 1, K_ERRACK = 2, K_RTY = 3, K_NONE = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
   logic [AW-1:0] cmd_adr = '0;
   logic [DW-1:0] cmd_dat = '0;
   logic [SW-1:0] cmd_sel = '0;
   logic          rsp_valid, rsp_ready = 1'b0;
   logic [DW-1:0] rsp_dat;
   logic [1:0]    rsp_status;
   logic [AW-1:0] wb_adr_o;
   logic [DW-1:0] wb_dat_o, wb_dat_i;
   logic [SW-1:0] wb_sel_o;
   logic          wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i, wb_rty_i;

   always #5 clk = ~clk;

   wb_cmd_master #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW),
      .TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_status(rsp_status),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i),
      .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   // Scripted slave: attempt a terminates with scr_kind[a] once STB has been sampled scr_delay[a] times.
   int            scr_kind[8];
   int            scr_delay[8];
   logic [DW-1:0] slv_rdata = '0;
   logic          stray_ack = 1'b0;
   logic          slv_term  = 1'b0;
   int            slv_cnt   = 0;
   int            slv_att   = 0;
   int            slv_kind;

   assign slv_kind = scr_kind[slv_att % 8];
   assign wb_ack_i = (slv_term && (slv_kind == K_ACK || slv_kind == K_ERRACK)) || stray_ack;
   assign wb_err_i = slv_term && (slv_kind == K_ERR || slv_kind == K_ERRACK);
   assign wb_rty_i = slv_term && (slv_kind == K_RTY);
   assign wb_dat_i = slv_rdata;

   always @(posedge clk) begin
      if (cmd_valid && cmd_ready) begin
         slv_att  <= 0;
         slv_cnt  <= 0;
         slv_term <= 1'b0;
      end else if (slv_term) begin
         slv_term <= 1'b0;
         slv_cnt  <= 0;
         slv_att  <= slv_att + 1;
      end else if (wb_stb_o) begin
         if (slv_kind != K_NONE && slv_cnt + 1 >= scr_delay[slv_att % 8]) slv_term <= 1'b1;
         else slv_cnt <= slv_cnt + 1;
      end else begin
         slv_cnt <= 0;
      end
   end

   // Model state
   logic          cur_we = 1'b0, pend_we = 1'b0;
   logic [AW-1:0] cur_adr = '0, pend_adr = '0;
   logic [DW-1:0] cur_dat = '0, pend_dat = '0;
   logic [SW-1:0] cur_sel = '0, pend_sel = '0;
   int            exp_lat, exp_stb, exp_att;
   logic [1:0]    exp_status;
   logic [DW-1:0] exp_dat;
   bit            busy   = 1'b0;
   bit            chk_en = 1'b0;
   int            got_lat, got_stb, got_att;
   logic [1:0]    got_status;
   logic [DW-1:0] got_dat;

   // Outcome of a command from the slave script: each attempt holds STB for delay+1 cycles
   // (or TO cycles if nothing terminates first); every retry adds one idle cycle.
   function automatic void predict();
      int retries = 0;
      bit done = 1'b0;
      exp_lat = 0; exp_stb = 0; exp_att = 0; exp_status = 2'd0; exp_dat = '0;
      for (int a = 0; a < 8 && !done; a++) begin
         int c;
         exp_att++;
         if (scr_kind[a] == K_NONE || scr_delay[a] + 1 > TO) begin
            c = TO; exp_status = 2'd2; done = 1'b1;
         end else begin
            c = scr_delay[a] + 1;
            if (scr_kind[a] == K_ERR || scr_kind[a] == K_ERRACK) begin
               exp_status = 2'd1; done = 1'b1;
            end else if (scr_kind[a] == K_ACK) begin
               exp_status = 2'd0; exp_dat = cur_we ? '0 : slv_rdata; done = 1'b1;
            end else if (retries < MR) begin
               retries++;
            end else begin
               exp_status = 2'd3; done = 1'b1;
            end
         end
         exp_stb += c;
         exp_lat += c + (done ? 0 : 1);
      end
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmd_ready", cmd_ready, !busy);
         chk("cyc_eq_stb", wb_cyc_o, wb_stb_o);
         if (!busy) chk("idle_quiet", {wb_cyc_o, rsp_valid}, 2'b00);
         if (wb_cyc_o) begin
            chk("wb_adr", wb_adr_o, cur_adr);
            chk("wb_dat", wb_dat_o, cur_dat);
            chk("wb_we_sel", {wb_we_o, wb_sel_o}, {cur_we, cur_sel});
         end
         if (rsp_valid) begin
            chk("rsp_dat_cyc", rsp_dat, exp_dat);
            chk("rsp_status_cyc", rsp_status, exp_status);
         end
      end
   end

   task automatic fill(input int kind, input int delay);
      for (int i = 0; i < 8; i++) begin
         scr_kind[i]  = kind;
         scr_delay[i] = delay;
      end
   endtask

   task automatic present(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                          input logic [SW-1:0] sel);
      cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
      pend_we = we; pend_adr = adr; pend_dat = dat; pend_sel = sel;
   endtask

   task automatic wait_accept();
      int n = 0;
      while (!cmd_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 50) chk("accept_bound", 0, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      busy = 1'b1;
      cur_we = pend_we; cur_adr = pend_adr; cur_dat = pend_dat; cur_sel = pend_sel;
      predict();
   endtask

   task automatic wait_rsp(input int hold, input bit pre, input logic nwe, input logic [AW-1:0] nadr);
      bit prev = 1'b0;
      got_lat = 0; got_stb = 0; got_att = 0;
      while (!rsp_valid && got_lat < 100) begin
         if (wb_stb_o) begin
            got_stb++;
            if (!prev) got_att++;
         end
         prev = wb_stb_o;
         @(posedge clk); #1; got_lat++;
      end
      if (got_lat >= 100) chk("rsp_bound", 0, 1);
      got_status = rsp_status;
      got_dat    = rsp_dat;
      chk("latency", got_lat, exp_lat);
      chk("stb_cycles", got_stb, exp_stb);
      chk("attempts", got_att, exp_att);
      chk("rsp_status", got_status, exp_status);
      chk("rsp_dat", got_dat, exp_dat);
      if (pre) present(nwe, nadr, 32'h0BAD_0000 | nadr, 4'h3);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", rsp_valid, 1'b1);
         chk("hold_dat", {rsp_status, rsp_dat}, {got_status, got_dat});
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      busy = 1'b0;
      chk("rsp_drop", rsp_valid, 1'b0);
      $display("txn we=%0d adr=%0h status=%0d dat=%0h lat=%0d att=%0d stb=%0d",
               cur_we, cur_adr, got_status, got_dat, got_lat, got_att, got_stb);
   endtask

   task automatic do_cmd(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [SW-1:0] sel, input int hold);
      present(we, adr, dat, sel);
      wait_accept();
      wait_rsp(hold, 1'b0, 1'b0, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      fill(K_ACK, 1);
      #1;
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_cyc_stb", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
      chk("rst_req", {wb_adr_o, wb_dat_o}, 64'h0);
      chk("rst_sel", wb_sel_o, 4'h0);
      chk("rst_rsp", {rsp_valid, rsp_status, rsp_dat}, 35'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      chk_en = 1'b1;
      @(posedge clk); #1;

      // 1: write 0x5, ack one cycle after STB
      fill(K_ACK, 1); slv_rdata = 32'hA5A5_0001;
      do_cmd(1'b1, 32'h0, 32'h5, 4'hF, 0);
      chk("t1_lat", got_lat, 2);
      chk("t1_att", got_att, 1);
      chk("t1_rsp", {got_status, got_dat}, 34'h0);

      // 2: read back 0x5
      slv_rdata = 32'h5;
      do_cmd(1'b0, 32'h0, 32'h0, 4'hF, 0);
      chk("t2_dat", got_dat, 32'h5);
      chk("t2_stb", got_stb, 2);

      // 3: ERR and ACK together
      fill(K_ERRACK, 1); slv_rdata = 32'hDEAD_BEEF;
      do_cmd(1'b0, 32'h10, 32'h0, 4'hF, 0);
      chk("t3_rsp", {got_status, got_dat}, {2'b01, 32'h0});

      // 4: RTY forever -> three reissues then RETRY_FAIL
      fill(K_RTY, 1);
      do_cmd(1'b1, 32'h20, 32'h77, 4'h1, 0);
      chk("t4_att", got_att, 4);
      chk("t4_lat", got_lat, 11);
      chk("t4_status", got_status, 2'b11);

      // 5: silent slave -> timeout after 8 STB cycles
      fill(K_NONE, 1);
      do_cmd(1'b0, 32'h30, 32'h0, 4'hF, 0);
      chk("t5_stb", got_stb, 8);
      chk("t5_status", got_status, 2'b10);

      // two retries then a delayed ACK
      fill(K_ACK, 2); scr_kind[0] = K_RTY; scr_kind[1] = K_RTY; scr_delay[1] = 3;
      slv_rdata = 32'h1234_5678;
      do_cmd(1'b0, 32'h40, 32'h0, 4'h3, 0);

      // ACK on the last cycle before timeout wins
      fill(K_ACK, 7);
      do_cmd(1'b1, 32'h50, 32'hCAFE_F00D, 4'hC, 0);
      chk("edge_lat", got_lat, 8);
      chk("edge_status", got_status, 2'b00);

      // next command presented while the response is stalled must wait, not be lost
      fill(K_ERR, 3);
      present(1'b1, 32'h60, 32'h6, 4'hF);
      wait_accept();
      wait_rsp(3, 1'b1, 1'b0, 32'h64);
      wait_accept();
      wait_rsp(0, 1'b0, 1'b0, '0);
      chk("queued_adr", cur_adr, 32'h64);

      // response held stable while rsp_ready is low
      fill(K_ACK, 1); slv_rdata = 32'h0000_CAFE;
      do_cmd(1'b0, 32'h70, 32'h0, 4'hF, 5);

      // stray ACK while idle is ignored
      stray_ack = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      stray_ack = 1'b0;
      chk("stray_idle", {cmd_ready, rsp_valid}, 2'b10);

      // reset mid-BUS drops the request without a clock edge
      fill(K_NONE, 1);
      present(1'b1, 32'h80, 32'h8, 4'hF);
      wait_accept();
      @(posedge clk); #2;
      chk_en = 1'b0;
      rst = 1'b0;
      #1;
      chk("arst_cyc_stb", {wb_cyc_o, wb_stb_o}, 2'b00);
      chk("arst_rsp_ready", {rsp_valid, cmd_ready}, 2'b01);
      busy = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_ready", cmd_ready, 1'b1);

      // normal traffic after reset
      fill(K_ACK, 2); slv_rdata = 32'h9999_0000;
      do_cmd(1'b0, 32'h90, 32'h0, 4'hF, 0);
      chk("post_rst_dat", got_dat, 32'h9999_0000);

      @(posedge clk); #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
